// File: rtl/entity_pkg.sv
// entity_pkg: shared definitions for the entity draw engine.
//   - ENTITY_W and the descriptor field positions (x, y, colour, active)
//   - one-hot class constants as presented by the draw controller
//   - compact sprite class encoding used for ROM addressing
//   - engine state encoding
package entity_pkg;

  localparam int ENTITY_W   = 30;
  localparam int X_MSB      = 29;
  localparam int X_LSB      = 21;
  localparam int Y_MSB      = 20;
  localparam int Y_LSB      = 13;
  localparam int COL_MSB    = 12;
  localparam int COL_LSB    = 10;
  localparam int ACTIVE_BIT = 9;

  localparam logic [2:0] D_SHIP     = 3'b100;
  localparam logic [2:0] D_ASTEROID = 3'b010;
  localparam logic [2:0] D_SHOT     = 3'b001;

  // Two-bit class code; it forms the top of the sprite ROM address.
  typedef enum logic [1:0] {
    CLS_SHIP     = 2'd0,
    CLS_ASTEROID = 2'd1,
    CLS_SHOT     = 2'd2,
    CLS_NONE     = 2'd3
  } sprite_class_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } engine_state_e;

  // Several bits set resolves as ship > asteroid > shot.
  function automatic sprite_class_e decode_class(input logic [2:0] onehot);
    if ((onehot & D_SHIP) != 3'b000)          return CLS_SHIP;
    else if ((onehot & D_ASTEROID) != 3'b000) return CLS_ASTEROID;
    else if ((onehot & D_SHOT) != 3'b000)     return CLS_SHOT;
    else                                      return CLS_NONE;
  endfunction

endpackage

// File: rtl/entity_draw_engine_if.sv
// entity_draw_engine_if: draw-controller handshake plus pixel plot bus.
//   master (controller/bench): drives draw_start, entity, entity_state
//   slave  (engine): drives busy, draw_done, plot, plot_x, plot_y, plot_colour
interface entity_draw_engine_if;
  import entity_pkg::*;

  logic                draw_start;
  logic [ENTITY_W-1:0] entity;
  logic [2:0]          entity_state;
  logic                busy;
  logic                draw_done;
  logic                plot;
  logic [8:0]          plot_x;
  logic [7:0]          plot_y;
  logic [2:0]          plot_colour;

  modport master (
    output draw_start, entity, entity_state,
    input  busy, draw_done, plot, plot_x, plot_y, plot_colour
  );

  modport slave (
    input  draw_start, entity, entity_state,
    output busy, draw_done, plot, plot_x, plot_y, plot_colour
  );

endinterface

// File: rtl/entity_sprite_rom.sv
// entity_sprite_rom: synchronous-read 1-bit sprite bitmap store.
//   clk  : clock
//   addr : {class[1:0], row[3:0], col[3:0]}
//   data : pixel bit, valid the cycle after addr is presented
// Ship is an outline arrow, asteroid a ring, shot a solid square.
module entity_sprite_rom
  import entity_pkg::*;
#(
  parameter int SHIP_SIZE     = 8,
  parameter int ASTEROID_SIZE = 16,
  parameter int SHOT_SIZE     = 2
) (
  input  logic       clk,
  input  logic [9:0] addr,
  output logic       data
);

  sprite_class_e cls;
  logic [3:0]    row;
  logic [3:0]    col;
  logic [7:0]    ship_bits;
  logic          pix;

  assign cls = sprite_class_e'(addr[9:8]);
  assign row = addr[7:4];
  assign col = addr[3:0];

  // Leftmost pixel of each row is bit 7.
  function automatic logic [7:0] ship_row(input logic [3:0] r);
    case (r)
      4'd0:    return 8'b0001_1000;
      4'd1:    return 8'b0010_0100;
      4'd2:    return 8'b0100_0010;
      4'd3:    return 8'b1000_0001;
      4'd4:    return 8'b1110_0111;
      4'd5:    return 8'b0010_0100;
      4'd6:    return 8'b0010_0100;
      4'd7:    return 8'b0011_1100;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // Distances are doubled so the sprite centre lands on integer coordinates.
  function automatic logic ring_bit(input logic [3:0] r, input logic [3:0] c);
    int dx;
    int dy;
    int d2;
    dx = 2 * int'(c) - (ASTEROID_SIZE - 1);
    dy = 2 * int'(r) - (ASTEROID_SIZE - 1);
    d2 = dx * dx + dy * dy;
    return (d2 >= (ASTEROID_SIZE - 6) * (ASTEROID_SIZE - 6)) &&
           (d2 <= ASTEROID_SIZE * ASTEROID_SIZE - 16);
  endfunction

  always_comb begin
    pix       = 1'b0;
    ship_bits = ship_row(row);
    case (cls)
      CLS_SHIP:
        if (int'(row) < SHIP_SIZE && int'(col) < SHIP_SIZE && int'(col) < 8)
          pix = ship_bits[3'd7 - col[2:0]];
      CLS_ASTEROID:
        if (int'(row) < ASTEROID_SIZE && int'(col) < ASTEROID_SIZE)
          pix = ring_bit(row, col);
      CLS_SHOT:
        if (int'(row) < SHOT_SIZE && int'(col) < SHOT_SIZE)
          pix = 1'b1;
      default:
        pix = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= pix;
  end

endmodule

// File: rtl/entity_draw_engine.sv
// entity_draw_engine: walks one entity's sprite and emits per-pixel plots.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : draw_start/entity/entity_state in; busy, draw_done,
//                  plot, plot_x, plot_y, plot_colour out
// Optional: define ENTITY_CLIP_EN to drop pixels falling off the visible
// screen instead of letting coordinates wrap.
module entity_draw_engine
  import entity_pkg::*;
#(
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter int SHIP_SIZE     = 8,
  parameter int ASTEROID_SIZE = 16,
  parameter int SHOT_SIZE     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  entity_draw_engine_if.slave  bus
);

  engine_state_e state_q, state_n;
  logic [4:0]    row_q, col_q, row_n, col_n;
  sprite_class_e cls_q, start_cls, rom_cls;
  logic [8:0]    x_q;
  logic [7:0]    y_q;
  logic [2:0]    colour_q;
  logic [4:0]    last_idx;
  logic          start_empty;
  logic [9:0]    rom_addr;
  logic          rom_bit;
  logic          on_screen;

  logic          plot_q;
  logic [8:0]    plot_x_q;
  logic [7:0]    plot_y_q;
  logic [2:0]    plot_colour_q;

  logic [8:0]    reserved_unused;
  logic [1:0]    ctr_msb_unused;

  assign reserved_unused = bus.entity[8:0];
  assign ctr_msb_unused  = {row_n[4], col_n[4]};

  function automatic logic [4:0] class_size(input sprite_class_e c);
    case (c)
      CLS_SHIP:     return 5'(SHIP_SIZE);
      CLS_ASTEROID: return 5'(ASTEROID_SIZE);
      CLS_SHOT:     return 5'(SHOT_SIZE);
      default:      return 5'd1;
    endcase
  endfunction

  assign start_cls   = decode_class(bus.entity_state);
  assign start_empty = (start_cls == CLS_NONE) || !bus.entity[ACTIVE_BIT];
  assign last_idx    = class_size(cls_q) - 5'd1;

  // The ROM is addressed with the *next* counter values, so its data lines
  // up with the current row/col and the plot registers can capture pixel
  // and coordinates at the same edge. An empty entity passes through DRAIN
  // so completion latency follows T+N+2 with N=0.
  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    col_n   = col_q;
    rom_cls = cls_q;
    case (state_q)
      S_IDLE: begin
        row_n   = 5'd0;
        col_n   = 5'd0;
        rom_cls = start_cls;
        if (bus.draw_start)
          state_n = start_empty ? S_DRAIN : S_SCAN;
      end
      S_SCAN: begin
        if (col_q == last_idx) begin
          col_n = 5'd0;
          row_n = row_q + 5'd1;
          if (row_q == last_idx)
            state_n = S_DRAIN;
        end else begin
          col_n = col_q + 5'd1;
        end
      end
      S_DRAIN: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign rom_addr = {rom_cls, row_n[3:0], col_n[3:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      row_q    <= 5'd0;
      col_q    <= 5'd0;
      cls_q    <= CLS_NONE;
      x_q      <= 9'd0;
      y_q      <= 8'd0;
      colour_q <= 3'd0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      if (state_q == S_IDLE && bus.draw_start) begin
        cls_q    <= start_cls;
        x_q      <= bus.entity[X_MSB:X_LSB];
        y_q      <= bus.entity[Y_MSB:Y_LSB];
        colour_q <= bus.entity[COL_MSB:COL_LSB];
      end
    end
  end

  entity_sprite_rom #(
    .SHIP_SIZE     (SHIP_SIZE),
    .ASTEROID_SIZE (ASTEROID_SIZE),
    .SHOT_SIZE     (SHOT_SIZE)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_bit)
  );

`ifdef ENTITY_CLIP_EN
  logic [9:0] x_sum;
  logic [8:0] y_sum;
  // Unwrapped sums, so a sprite straddling the right/bottom edge is cut.
  assign x_sum     = {1'b0, x_q} + {5'b0, col_q};
  assign y_sum     = {1'b0, y_q} + {4'b0, row_q};
  assign on_screen = (x_sum < 10'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));
`else
  assign on_screen = 1'b1;
`endif

  // Coordinates/colour only move on a real write so they hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      plot_q        <= 1'b0;
      plot_x_q      <= 9'd0;
      plot_y_q      <= 8'd0;
      plot_colour_q <= 3'd0;
    end else begin
      plot_q <= 1'b0;
      if (state_q == S_SCAN && rom_bit && on_screen) begin
        plot_q        <= 1'b1;
        plot_x_q      <= x_q + {4'b0, col_q};
        plot_y_q      <= y_q + {3'b0, row_q};
        plot_colour_q <= colour_q;
      end
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.draw_done   = (state_q == S_DONE);
  assign bus.plot        = plot_q;
  assign bus.plot_x      = plot_x_q;
  assign bus.plot_y      = plot_y_q;
  assign bus.plot_colour = plot_colour_q;

endmodule

// File: tb/tb_entity_draw_engine.sv
// tb_entity_draw_engine: directed self-checking bench for entity_draw_engine.
// Cycle k below is counted from the start cycle T (k=0); outputs are
// sampled 1ns after each rising edge.
module tb_entity_draw_engine;
  import entity_pkg::*;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  entity_draw_engine_if bus();

  entity_draw_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int px_q[$];
  int py_q[$];
  int pc_q[$];
  int pk_q[$];
  int obs_done_at;
  int obs_done_cnt;
  int obs_busy_first;
  int obs_busy_last;
  int obs_busy_cycles;

  localparam int SHIP_POPCOUNT = 22;

  function automatic logic [29:0] mk_entity(input int x, input int y, input int c, input bit act);
    logic [29:0] e;
    e        = '0;
    e[29:21] = x[8:0];
    e[20:13] = y[7:0];
    e[12:10] = c[2:0];
    e[9]     = act;
    e[8:0]   = 9'h15A;
    return e;
  endfunction

  task automatic begin_draw(input logic [29:0] e, input logic [2:0] st);
    @(posedge clk); #1;
    bus.entity       = e;
    bus.entity_state = st;
    bus.draw_start   = 1'b1;
  endtask

  // Records what the engine does after a start; decides nothing itself.
  task automatic observe(input int budget, input int extra_after, input int start_again_at,
                         input int change_at, input logic [29:0] alt_entity);
    px_q.delete(); py_q.delete(); pc_q.delete(); pk_q.delete();
    obs_done_at = -1; obs_done_cnt = 0;
    obs_busy_first = -1; obs_busy_last = -1; obs_busy_cycles = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      bus.draw_start = (k == start_again_at);
      if (k == change_at) bus.entity = alt_entity;
      if (bus.plot === 1'b1) begin
        px_q.push_back(int'(bus.plot_x));
        py_q.push_back(int'(bus.plot_y));
        pc_q.push_back(int'(bus.plot_colour));
        pk_q.push_back(k);
      end
      if (bus.draw_done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_at < 0) obs_done_at = k;
      end
      if (bus.busy === 1'b1) begin
        obs_busy_cycles++;
        if (obs_busy_first < 0) obs_busy_first = k;
        obs_busy_last = k;
      end
      if (obs_done_at > 0 && k >= obs_done_at + extra_after) break;
    end
    bus.draw_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.draw_done, bus.plot} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy, bus.draw_done, bus.plot});
    end
    vectors++;
    if (bus.plot_x !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_plot_x: got %0d expected 0", bus.plot_x);
    end
    vectors++;
    if ({bus.plot_y, bus.plot_colour} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_plot_y_colour: got %0d/%0d expected 0/0", bus.plot_y, bus.plot_colour);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_shot();
    int ex[4] = '{100, 101, 100, 101};
    int ey[4] = '{50, 50, 51, 51};
    begin_draw(mk_entity(100, 50, 5, 1'b1), D_SHOT);
    observe(40, 3, -1, -1, '0);
    vectors++;
    if (px_q.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL shot_plot_count: got %0d expected 4", px_q.size());
    end
    for (int i = 0; i < 4 && i < px_q.size(); i++) begin
      vectors++;
      if (px_q[i] !== ex[i] || py_q[i] !== ey[i] || pc_q[i] !== 5 || pk_q[i] !== i + 2) begin
        miscompares++;
        $display("[TB] FAIL shot_pixel%0d: got (%0d,%0d) c%0d @T+%0d expected (%0d,%0d) c5 @T+%0d",
                 i, px_q[i], py_q[i], pc_q[i], pk_q[i], ex[i], ey[i], i + 2);
      end
    end
    vectors++;
    if (obs_done_at !== 6 || obs_done_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL shot_done: got T+%0d x%0d expected T+6 x1", obs_done_at, obs_done_cnt);
    end
    vectors++;
    if (obs_busy_first !== 1 || obs_busy_last !== 6 || obs_busy_cycles !== 6) begin
      miscompares++;
      $display("[TB] FAIL shot_busy: got T+%0d..T+%0d (%0d cycles) expected T+1..T+6 (6)",
               obs_busy_first, obs_busy_last, obs_busy_cycles);
    end
  endtask

  task automatic test_ship();
    int bad;
    begin_draw(mk_entity(10, 20, 3, 1'b1), D_SHIP | D_SHOT);
    observe(120, 3, -1, -1, '0);
    vectors++;
    if (obs_done_at !== 66 || obs_done_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL ship_done: got T+%0d x%0d expected T+66 x1", obs_done_at, obs_done_cnt);
    end
    vectors++;
    if (px_q.size() !== SHIP_POPCOUNT) begin
      miscompares++;
      $display("[TB] FAIL ship_plot_count: got %0d expected %0d", px_q.size(), SHIP_POPCOUNT);
    end
    bad = 0;
    foreach (px_q[i])
      if (px_q[i] < 10 || px_q[i] > 17 || py_q[i] < 20 || py_q[i] > 27 ||
          pc_q[i] != 3 || pk_q[i] < 2 || pk_q[i] > 65) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL ship_bounds: got %0d bad plots expected 0", bad);
    end
  endtask

  task automatic test_empty();
    begin_draw(mk_entity(30, 40, 7, 1'b1), 3'b000);
    observe(20, 3, -1, -1, '0);
    vectors++;
    if (px_q.size() !== 0 || obs_done_at !== 2 || obs_done_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL empty_class: got %0d plots done T+%0d x%0d expected 0 plots done T+2 x1",
               px_q.size(), obs_done_at, obs_done_cnt);
    end
    begin_draw(mk_entity(30, 40, 7, 1'b0), D_ASTEROID);
    observe(20, 3, -1, -1, '0);
    vectors++;
    if (px_q.size() !== 0 || obs_done_at !== 2 || obs_done_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL inactive_asteroid: got %0d plots done T+%0d x%0d expected 0 plots done T+2 x1",
               px_q.size(), obs_done_at, obs_done_cnt);
    end
  endtask

  task automatic test_edge();
    int bad;
    int right;
    int below;
    begin_draw(mk_entity(315, 235, 2, 1'b1), D_ASTEROID | D_SHOT);
    observe(400, 3, -1, -1, '0);
    vectors++;
    if (obs_done_at !== 258 || obs_done_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL edge_done: got T+%0d x%0d expected T+258 x1", obs_done_at, obs_done_cnt);
    end
    bad = 0; right = 0; below = 0;
    foreach (px_q[i]) begin
      if (px_q[i] >= 320) right++;
      if (py_q[i] >= 240) below++;
      if (px_q[i] < 315 || px_q[i] > 330 || py_q[i] < 235 || py_q[i] > 250) bad++;
    end
`ifdef ENTITY_CLIP_EN
    vectors++;
    if (right !== 0 || below !== 0 || px_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL edge_clip: got %0d right %0d below of %0d plots expected 0 0 of >0",
               right, below, px_q.size());
    end
`else
    vectors++;
    if (bad !== 0 || right == 0 || below == 0) begin
      miscompares++;
      $display("[TB] FAIL edge_wrap: got %0d out-of-range %0d right %0d below expected 0 >0 >0",
               bad, right, below);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    int bad;
    begin_draw(mk_entity(40, 60, 6, 1'b1), D_SHIP);
    observe(120, 3, 5, 3, mk_entity(200, 100, 1, 1'b1));
    vectors++;
    if (obs_done_at !== 66 || obs_done_cnt !== 1 || px_q.size() !== SHIP_POPCOUNT) begin
      miscompares++;
      $display("[TB] FAIL ignore_done: got T+%0d x%0d %0d plots expected T+66 x1 %0d plots",
               obs_done_at, obs_done_cnt, px_q.size(), SHIP_POPCOUNT);
    end
    bad = 0;
    foreach (px_q[i])
      if (px_q[i] < 40 || px_q[i] > 47 || py_q[i] < 60 || py_q[i] > 67 || pc_q[i] != 6) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL ignore_latched: got %0d plots off original descriptor expected 0", bad);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_not_queued: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    begin_draw(mk_entity(7, 9, 4, 1'b1), D_SHOT);
    observe(40, 0, -1, -1, '0);
    vectors++;
    if (obs_done_at !== 6) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_done: got T+%0d expected T+6", obs_done_at);
    end
    begin_draw(mk_entity(7, 9, 4, 1'b1), D_SHOT);
    observe(40, 3, -1, -1, '0);
    vectors++;
    if (obs_done_at !== 6 || px_q.size() !== 4 || obs_busy_first !== 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_restart: got done T+%0d %0d plots busy from T+%0d expected T+6 4 T+1",
               obs_done_at, px_q.size(), obs_busy_first);
    end
  endtask

  task automatic test_mid_reset();
    int late_done;
    begin_draw(mk_entity(50, 60, 3, 1'b1), D_ASTEROID);
    observe(29, 0, -1, -1, '0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    vectors++;
    if ({bus.busy, bus.draw_done, bus.plot} !== 3'b000 || bus.plot_x !== 9'd0 ||
        bus.plot_y !== 8'd0 || bus.plot_colour !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got b%b d%b p%b (%0d,%0d) c%0d expected all 0",
               bus.busy, bus.draw_done, bus.plot, bus.plot_x, bus.plot_y, bus.plot_colour);
    end
    late_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.draw_done === 1'b1 || bus.busy === 1'b1) late_done++;
    end
    vectors++;
    if (late_done !== 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_done: got %0d busy/done cycles expected 0", late_done);
    end
    begin_draw(mk_entity(50, 60, 3, 1'b1), D_ASTEROID);
    observe(400, 3, -1, -1, '0);
    vectors++;
    if (obs_done_at !== 258 || obs_done_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL midreset_fresh_done: got T+%0d x%0d expected T+258 x1", obs_done_at, obs_done_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset_n          = 1'b0;
    bus.draw_start   = 1'b0;
    bus.entity       = '0;
    bus.entity_state = 3'b000;
    test_reset();
    test_shot();
    test_ship();
    test_empty();
    test_edge();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
